// File: rtl/bft_router_sync_pkg.sv
// Shared types and the routing decision for the butterfly-fat-tree router.
// Default widths here match the router's default parameters.
package bft_router_sync_pkg;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_PAYLOAD_W = 5;
  localparam int DEF_FLIT_W    = DEF_ADDR_W + DEF_PAYLOAD_W;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]    dest;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } flit_t;

  // Returns the output port index for a head flit. Parent traffic always goes down;
  // child traffic goes down only when the destination lies in this subtree.
  function automatic int unsigned route_dest(
    input logic [31:0] dest,
    input int unsigned addr_w,
    input int unsigned prefix_len,
    input logic [31:0] my_prefix,
    input int unsigned csel_w,
    input logic        from_parent,
    input int unsigned parent_idx
  );
    logic [31:0] pfx;
    logic [31:0] child;
    pfx   = (dest >> (addr_w - prefix_len)) & ((32'd1 << prefix_len) - 32'd1);
    child = (dest >> (addr_w - prefix_len - csel_w)) & ((32'd1 << csel_w) - 32'd1);
    if (from_parent || (prefix_len == 0) || (pfx == my_prefix)) return child;
    return parent_idx;
  endfunction

endpackage

// File: rtl/bft_router_sync_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer advances past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_grant_en,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_pick;
  logic [PW-1:0] w_idx;

  always_comb begin
    w_pick    = '0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N);
      if ((w_pick == '0) && i_req[w_idx]) begin
        w_pick[w_idx] = 1'b1;
        w_ptr_nxt     = PW'((int'(w_idx) + 1) % N);
      end
    end
  end

  assign o_gnt = i_grant_en ? w_pick : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ptr <= '0;
    else if (i_grant_en && (|i_req))
      r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/bft_router_sync.sv
// Clocked butterfly-fat-tree router: per-input FIFOs, per-output RR arbitration and
// one-entry output registers. Define ROUTER_STATS_EN for per-output flit counters.
module bft_router_sync
  import bft_router_sync_pkg::*;
#(
  parameter int NUM_CHILD  = 2,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PAYLOAD_W  = DEF_PAYLOAD_W,
  parameter int PREFIX_LEN = 2,
  parameter logic [((PREFIX_LEN > 0) ? PREFIX_LEN : 1)-1:0] MY_PREFIX = 2'b01,
  parameter int FIFO_DEPTH = 2,
  localparam int NP        = NUM_CHILD + 1,
  localparam int FLIT_W    = ADDR_W + PAYLOAD_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NP-1:0]        i_in_valid,
  output logic [NP-1:0]        o_in_ready,
  input  logic [NP*FLIT_W-1:0] i_in_data,
  output logic [NP-1:0]        o_out_valid,
  input  logic [NP-1:0]        i_out_ready,
  output logic [NP*FLIT_W-1:0] o_out_data,
  output logic [NP*16-1:0]     o_stats_cnt
);

  localparam int CSEL_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [NP-1:0][FLIT_W-1:0] w_head;
  logic [NP-1:0][FLIT_W-1:0] w_sel;
  logic [NP-1:0]             w_head_vld;
  logic [NP-1:0]             w_push;
  logic [NP-1:0]             w_pop;
  logic [NP-1:0]             w_load;
  logic [NP-1:0][NP-1:0]     w_req;   // [output][input]
  logic [NP-1:0][NP-1:0]     w_gnt;   // [output][input]

  for (genvar gi = 0; gi < NP; gi++) begin : g_in
    logic [FLIT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_cnt;

    // Ready comes from registered occupancy only, so a full FIFO refuses even while popping.
    assign o_in_ready[gi] = (r_cnt != FULL_CNT);
    assign w_push[gi]     = i_in_valid[gi] && o_in_ready[gi];
    assign w_head_vld[gi] = (r_cnt != '0);
    assign w_head[gi]     = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
      if (w_push[gi]) r_mem[r_wptr] <= i_in_data[gi*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[gi])  r_rptr <= r_rptr + 1'b1;
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NP; i++) begin
      for (int o = 0; o < NP; o++) begin
        if (w_head_vld[i] &&
            (route_dest(32'(w_head[i][FLIT_W-1 -: ADDR_W]), ADDR_W, PREFIX_LEN,
                        32'(MY_PREFIX), CSEL_W, (i == NUM_CHILD), NUM_CHILD) == o))
          w_req[o][i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    w_sel = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (w_gnt[o][i]) begin
          w_pop[i] = 1'b1;
          w_sel[o] = w_head[i];
        end
      end
    end
  end

  for (genvar go = 0; go < NP; go++) begin : g_out
    logic              r_vld;
    logic [FLIT_W-1:0] r_dat;

    // The output register may refill on the same edge it drains.
    assign w_load[go] = !r_vld || i_out_ready[go];

    rr_arbiter #(.N(NP)) u_arb (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_req      (w_req[go]),
      .i_grant_en (w_load[go]),
      .o_gnt      (w_gnt[go])
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else if (w_load[go]) begin
        r_vld <= |w_gnt[go];
        if (|w_gnt[go]) r_dat <= w_sel[go];
      end
    end

    assign o_out_valid[go]                 = r_vld;
    assign o_out_data[go*FLIT_W +: FLIT_W] = r_dat;

`ifdef ROUTER_STATS_EN
    logic [15:0] r_stats;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
        r_stats <= '0;
      else if (r_vld && i_out_ready[go] && (r_stats != 16'hFFFF))
        r_stats <= r_stats + 16'd1;
    end
    assign o_stats_cnt[go*16 +: 16] = r_stats;
`else
    assign o_stats_cnt[go*16 +: 16] = 16'h0000;
`endif
  end

endmodule

// File: tb/tb_bft_router_sync.sv
// Scoreboard bench for bft_router_sync: expected flits queued per (input, output) on
// acceptance, matched against each output handshake.
module tb_bft_router_sync;
  import bft_router_sync_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_ready;
  logic [26:0] in_data = '0;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready = '0;
  logic [26:0] out_data;
  logic [47:0] stats_cnt;

  logic [8:0] send_q [3][$];
  logic [8:0] exp_q  [9][$];
  int src_log [$];
  int hs_cyc  [$];
  int sent_to [3];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bft_router_sync #(
    .NUM_CHILD (2), .ADDR_W (4), .PAYLOAD_W (5), .PREFIX_LEN (2),
    .MY_PREFIX (2'b01), .FIFO_DEPTH (2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_stats_cnt (stats_cnt)
  );

  function automatic logic [8:0] mk(input logic [3:0] d, input logic [4:0] p);
    flit_t f;
    f.dest    = d;
    f.payload = p;
    return f;
  endfunction

  // Reference routing for NUM_CHILD=2, PREFIX_LEN=2, MY_PREFIX=01: child select is dest[1].
  function automatic int model_route(input int src, input logic [8:0] f);
    if (src == 2) return int'(f[6]);
    if (f[8:7] == 2'b01) return int'(f[6]);
    return 2;
  endfunction

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      in_valid[i]         = (send_q[i].size() > 0);
      in_data[i*9 +: 9]   = (send_q[i].size() > 0) ? send_q[i][0] : 9'h000;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      send_q[i].delete();
      sent_to[i] = 0;
    end
    for (int k = 0; k < 9; k++) exp_q[k].delete();
    apply();
  endtask

  task automatic tick();
    logic [8:0] f;
    logic       found;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        f = send_q[i].pop_front();
        exp_q[i*3 + model_route(i, f)].push_back(f);
        sent_to[model_route(i, f)]++;
      end
    end
    for (int o = 0; o < 3; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        f     = out_data[o*9 +: 9];
        found = 1'b0;
        for (int s = 0; s < 3; s++) begin
          if (!found && exp_q[s*3+o].size() > 0 && exp_q[s*3+o][0] == f) begin
            found = 1'b1;
            void'(exp_q[s*3+o].pop_front());
            if (o == 1) begin
              src_log.push_back(s);
              hs_cyc.push_back(cyc);
            end
          end
        end
        total++;
        if (!found) begin
          bad++;
          $display("FAIL scoreboard out%0d: got flit %h, expected head of some input queue", o, f);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    apply();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    total++; if (out_valid !== 3'b000) begin bad++; $display("FAIL reset_out_valid: got %b want 000", out_valid); end
    total++; if (in_ready !== 3'b111) begin bad++; $display("FAIL reset_in_ready: got %b want 111", in_ready); end
    total++; if (out_data !== 27'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (stats_cnt !== 48'h0) begin bad++; $display("FAIL reset_stats: got %h want 0", stats_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_routing();
    out_ready = 3'b111;
    send_q[0].push_back(mk(4'b0110, 5'h15));
    apply();
    tick();
    total++; if (out_valid !== 3'b000) begin bad++; $display("FAIL latency_early: got %b want 000", out_valid); end
    tick();
    total++; if (out_valid !== 3'b010) begin bad++; $display("FAIL latency_valid: got %b want 010", out_valid); end
    total++; if (out_data[17:9] !== 9'h0D5) begin bad++; $display("FAIL route_data: got %h want 0d5", out_data[17:9]); end
    send_q[1].push_back(mk(4'b1100, 5'h01));
    send_q[2].push_back(mk(4'b0100, 5'h02));
    send_q[2].push_back(mk(4'b1110, 5'h03));
    apply();
    repeat (8) tick();
    for (int k = 0; k < 9; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin bad++; $display("FAIL routing_lost q%0d: got %0d left want 0", k, exp_q[k].size()); end
    end
    total++; if (out_valid !== 3'b000) begin bad++; $display("FAIL routing_idle: got %b want 000", out_valid); end
  endtask

  task automatic test_back_to_back();
    src_log.delete();
    hs_cyc.delete();
    out_ready = 3'b111;
    for (int k = 0; k < 4; k++) begin
      send_q[0].push_back(mk(4'b0110, 5'(k)));
      send_q[2].push_back(mk(4'b1110, 5'(16 + k)));
    end
    apply();
    repeat (16) tick();
    total++;
    if (src_log.size() != 8) begin bad++; $display("FAIL rr_count: got %0d want 8", src_log.size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < src_log.size()) begin
        total++;
        if (src_log[k] != ((k % 2 == 0) ? 0 : 2)) begin
          bad++; $display("FAIL rr_order[%0d]: got in%0d want in%0d", k, src_log[k], (k % 2 == 0) ? 0 : 2);
        end
      end
    end
    if (hs_cyc.size() == 8) begin
      total++;
      if (hs_cyc[7] - hs_cyc[0] != 7) begin bad++; $display("FAIL rr_throughput: got span %0d want 7", hs_cyc[7] - hs_cyc[0]); end
    end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin bad++; $display("FAIL rr_lost q%0d: got %0d left want 0", k, exp_q[k].size()); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 3'b101;
    for (int k = 0; k < 5; k++) send_q[0].push_back(mk(4'b0110, 5'(8 + k)));
    apply();
    repeat (6) tick();
    total++; if (send_q[0].size() != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 3", 5 - send_q[0].size()); end
    total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready[0]); end
    total++; if (out_valid[1] !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", out_valid[1]); end
    total++; if (out_data[17:9] !== mk(4'b0110, 5'd8)) begin bad++; $display("FAIL bp_head: got %h want %h", out_data[17:9], mk(4'b0110, 5'd8)); end
    repeat (3) tick();
    total++; if (out_data[17:9] !== mk(4'b0110, 5'd8)) begin bad++; $display("FAIL bp_stable: got %h want %h", out_data[17:9], mk(4'b0110, 5'd8)); end
    out_ready = 3'b111;
    repeat (10) tick();
    total++; if (send_q[0].size() != 0) begin bad++; $display("FAIL bp_unsent: got %0d want 0", send_q[0].size()); end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin bad++; $display("FAIL bp_lost q%0d: got %0d left want 0", k, exp_q[k].size()); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 3'b111;
    for (int k = 0; k < 6; k++) send_q[0].push_back(mk(4'b0110, 5'(k)));
    for (int k = 0; k < 4; k++) send_q[1].push_back(mk(4'b1100, 5'(20 + k)));
    apply();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 3'b000) begin bad++; $display("FAIL arst_out_valid: got %b want 000", out_valid); end
    total++; if (in_ready !== 3'b111) begin bad++; $display("FAIL arst_in_ready: got %b want 111", in_ready); end
    total++; if (stats_cnt !== 48'h0) begin bad++; $display("FAIL arst_stats: got %h want 0", stats_cnt); end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_q[2].push_back(mk(4'b0100, 5'h0A));
    send_q[0].push_back(mk(4'b0110, 5'h0B));
    send_q[1].push_back(mk(4'b1000, 5'h0C));
    apply();
    repeat (8) tick();
    for (int k = 0; k < 9; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin bad++; $display("FAIL arst_lost q%0d: got %0d left want 0", k, exp_q[k].size()); end
    end
  endtask

  task automatic test_stats();
    int want;
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 3'b111;
    for (int k = 0; k < 5; k++) send_q[2].push_back(mk(4'b0000, 5'(k)));
    apply();
    repeat (10) tick();
    for (int o = 0; o < 3; o++) begin
`ifdef ROUTER_STATS_EN
      want = sent_to[o];
`else
      want = 0;
`endif
      total++;
      if (stats_cnt[o*16 +: 16] !== 16'(want)) begin
        bad++; $display("FAIL stats[%0d]: got %0d want %0d", o, stats_cnt[o*16 +: 16], want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
